// File: rtl/mem_access_sequencer_if.sv
// Bundles the CPU request/response channels, the memory-side lines and the
// statistics outputs of mem_access_sequencer.
interface mem_access_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_rdata;
  logic        resp_fault;

  logic [7:0]  mem_address;
  logic        mem_write;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;

  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
  logic [15:0] stat_faults;

  // Sequencer side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write, mem_data_in,
    output stat_reads, stat_writes, stat_faults
  );

  // CPU and memory side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write, mem_data_in,
    input  stat_reads, stat_writes, stat_faults
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer in front of the 256-byte memory: absorbs the one-cycle read latency,
// blocks illegal stores. Define ACCESS_STATS_EN to build the saturating access counters.
module mem_access_sequencer #(
  parameter logic [7:0] ROM_TOP = 8'h80,
  parameter logic [7:0] RW_TOP  = 8'hE0,
  parameter logic [7:0] IN_TOP  = 8'hF0
) (
  input logic                   clk,
  input logic                   reset,
  mem_access_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture, StResp} state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [7:0] rdata_q, rdata_d;
  logic       fault_q, fault_d;
  logic       legal;
  logic       done;

  // Stores into ROM or the input-port window are refused; every load is legal.
  always_comb begin
    legal = 1'b1;
    if (we_q && ((addr_q < ROM_TOP) || ((addr_q >= RW_TOP) && (addr_q < IN_TOP)))) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          we_d    = bus.req_we;
          state_d = StAccess;
        end
      end
      StAccess: state_d = StCapture;
      StCapture: begin
        // Output ports have no readable contents, so their loads return zero.
        rdata_d = (!we_q && (addr_q < IN_TOP)) ? bus.mem_data_out : 8'h00;
        fault_d = !legal;
        state_d = StResp;
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign done = (state_q == StResp) && bus.resp_ready;

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.resp_valid  = (state_q == StResp);
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_fault  = fault_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;
  // Gated by reset so a reset arriving during ACCESS kills the write on that same edge.
  assign bus.mem_write   = (state_q == StAccess) && we_q && legal && reset;

`ifdef ACCESS_STATS_EN
  logic [15:0] reads_q, reads_d;
  logic [15:0] writes_q, writes_d;
  logic [15:0] faults_q, faults_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    faults_d = faults_q;
    if (done) begin
      if (fault_q)   faults_d = sat_inc(faults_q);
      else if (we_q) writes_d = sat_inc(writes_q);
      else           reads_d  = sat_inc(reads_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      reads_q  <= 16'h0000;
      writes_q <= 16'h0000;
      faults_q <= 16'h0000;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      faults_q <= faults_d;
    end
  end

  assign bus.stat_reads  = reads_q;
  assign bus.stat_writes = writes_q;
  assign bus.stat_faults = faults_q;
`else
  logic unused_done;
  assign unused_done     = done;
  assign bus.stat_reads  = 16'h0000;
  assign bus.stat_writes = 16'h0000;
  assign bus.stat_faults = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer with a behavioural 256-byte memory
// (ROM/RW contents = addr ^ 0x3C, input ports from in_port[]).
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  mem_access_sequencer_if bus ();

  mem_access_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rdata;
    logic       fault;
    string      name;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         wr_count = 0;
  logic [7:0] wr_addr, wr_data;

  logic [7:0] mem [256];
  logic [7:0] in_port [16];
  logic       mem_loaded = 1'b0;

  // Memory model: one-cycle synchronous read, writes whatever it is told to.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h3C;
      mem_loaded <= 1'b1;
    end else if (bus.mem_write) begin
      mem[bus.mem_address] <= bus.mem_data_in;
    end
    if (bus.mem_address >= 8'hE0 && bus.mem_address < 8'hF0)
      bus.mem_data_out <= in_port[bus.mem_address[3:0]];
    else
      bus.mem_data_out <= mem[bus.mem_address];
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.resp_valid && bus.resp_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata 0x%0h fault %0b, expected no response",
                   bus.resp_rdata, bus.resp_fault);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_rdata"}, 16'(bus.resp_rdata), 16'(e.rdata));
          check({e.name, "_fault"}, 16'(bus.resp_fault), 16'(e.fault));
        end
      end
    end
  end

  // Write monitor: one count per cycle with mem_write high.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_write) begin
        wr_count++;
        wr_addr = bus.mem_address;
        wr_data = bus.mem_data_in;
      end
    end
  end

  task automatic drive_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  // Presents a request and returns #1 after the acceptance edge.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp_rdata, input logic exp_fault, input string name);
    int n;
    sb_q.push_back(exp_t'{exp_rdata, exp_fault, name});
    drive_req(we, addr, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) check({name, "_accept_timeout"}, 16'(bus.req_ready), 16'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check({name, "_idle_timeout"}, 16'(bus.req_ready), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_rdata, input logic exp_fault, input string name);
    int w0;
    w0 = wr_count;
    issue(we, addr, wdata, exp_rdata, exp_fault, name);
    @(negedge clk) check({name, "_lat_t0"}, 16'(bus.resp_valid), 16'd0);
    @(negedge clk) check({name, "_lat_t1"}, 16'(bus.resp_valid), 16'd0);
    @(negedge clk) check({name, "_lat_t2"}, 16'(bus.resp_valid), 16'd1);
    wait_idle(name);
    check({name, "_wr_cycles"}, 16'(wr_count - w0), (we && !exp_fault) ? 16'd1 : 16'd0);
    if (we && !exp_fault) begin
      check({name, "_wr_addr"}, 16'(wr_addr), 16'(addr));
      check({name, "_wr_data"}, 16'(wr_data), 16'(wdata));
    end
  endtask

  task automatic check_stats(input string name, input logic [15:0] r, input logic [15:0] w,
                             input logic [15:0] f);
    check({name, "_reads"},  bus.stat_reads,  r);
    check({name, "_writes"}, bus.stat_writes, w);
    check({name, "_faults"}, bus.stat_faults, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, n;
    for (int i = 0; i < 16; i++) in_port[i] = 8'(i) * 8'h11;
    in_port[3]  = 8'hC4;
    in_port[15] = 8'h9D;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 8'h00;
    bus.resp_ready = 1'b1;

    // Reset held low for two edges.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready",   16'(bus.req_ready),   16'd1);
    check("rst_resp_valid",  16'(bus.resp_valid),  16'd0);
    check("rst_mem_write",   16'(bus.mem_write),   16'd0);
    check("rst_mem_address", 16'(bus.mem_address), 16'h00);
    check("rst_mem_data_in", 16'(bus.mem_data_in), 16'h00);
    check("rst_resp_rdata",  16'(bus.resp_rdata),  16'h00);
    check("rst_resp_fault",  16'(bus.resp_fault),  16'd0);
    check_stats("rst_stat", 16'h0000, 16'h0000, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b1;

    // RW store then load back.
    txn(1'b1, 8'h90, 8'h5A, 8'h00, 1'b0, "st90");
    txn(1'b0, 8'h90, 8'h00, 8'h5A, 1'b0, "ld90");

    // Illegal stores: ROM and input-port window.
    txn(1'b1, 8'h10, 8'h33, 8'h00, 1'b1, "st10_rom");
    txn(1'b1, 8'hE5, 8'h77, 8'h00, 1'b1, "stE5_inport");
`ifdef ACCESS_STATS_EN
    check_stats("stat_mid", 16'd1, 16'd1, 16'd2);
`else
    check_stats("stat_mid", 16'd0, 16'd0, 16'd0);
`endif
    txn(1'b0, 8'h10, 8'h00, 8'h2C, 1'b0, "ld10_rom");

    // Input ports and output-port loads.
    txn(1'b0, 8'hE3, 8'h00, 8'hC4, 1'b0, "ldE3_inport");
    txn(1'b0, 8'hF2, 8'h00, 8'h00, 1'b0, "ldF2_outport");

    // Region boundaries.
    txn(1'b1, 8'h7F, 8'h01, 8'h00, 1'b1, "st7F_rom_top");
    txn(1'b1, 8'h80, 8'h02, 8'h00, 1'b0, "st80_rw_base");
    txn(1'b1, 8'hDF, 8'h03, 8'h00, 1'b0, "stDF_rw_top");
    txn(1'b1, 8'hE0, 8'h04, 8'h00, 1'b1, "stE0_in_base");
    txn(1'b1, 8'hEF, 8'h05, 8'h00, 1'b1, "stEF_in_top");
    txn(1'b1, 8'hF0, 8'h06, 8'h00, 1'b0, "stF0_out_base");
    txn(1'b0, 8'hEF, 8'h00, 8'h9D, 1'b0, "ldEF_in_top");
    txn(1'b0, 8'hDF, 8'h00, 8'h03, 1'b0, "ldDF_rw_top");

    // Stalled response with req_valid toggling underneath.
    w0 = wr_count;
    bus.resp_ready = 1'b0;
    issue(1'b0, 8'h85, 8'h00, 8'hB9, 1'b0, "ld85_stall");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 10);
    check("stall_resp_seen", 16'(bus.resp_valid), 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 drive_req(1'b1, 8'h90, 8'hEE);
      bus.req_valid = (i % 2 == 0);
      @(negedge clk);
      check("stall_resp_valid", 16'(bus.resp_valid), 16'd1);
      check("stall_resp_rdata", 16'(bus.resp_rdata), 16'hB9);
      check("stall_req_ready",  16'(bus.req_ready),  16'd0);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk) check("stall_hs_req_ready", 16'(bus.req_ready), 16'd0);
    @(negedge clk);
    check("stall_after_req_ready",  16'(bus.req_ready),  16'd1);
    check("stall_after_resp_valid", 16'(bus.resp_valid), 16'd0);
    check("stall_no_queued_write",  16'(wr_count - w0),  16'd0);
    @(posedge clk);
    #1;

    // Reset during ACCESS of a store: write suppressed, transaction dropped.
    w0 = wr_count;
    drive_req(1'b1, 8'h90, 8'hAA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready && n < 50);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk) check("rstmid_mem_write", 16'(bus.mem_write), 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstmid_req_ready",   16'(bus.req_ready),   16'd1);
    check("rstmid_mem_address", 16'(bus.mem_address), 16'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) check("rstmid_no_resp", 16'(bus.resp_valid), 16'd0);
    end
    check("rstmid_no_write", 16'(wr_count - w0), 16'd0);
    @(posedge clk);
    #1;
    txn(1'b0, 8'h90, 8'h00, 8'h5A, 1'b0, "ld90_after_rst");

    repeat (3) @(negedge clk);
    check("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Bus-side sequencer directly upstream of the 256-byte memory block (ROM 0x00-0x7F, RW 0x80-0xDF, input ports 0xE0-0xEF, output ports 0xF0-0xFF).
- Accepts single-byte load/store requests from the CPU core over a valid/ready handshake and drives the memory's address, write and data_in lines.
- Absorbs the memory's one-cycle synchronous read latency and rejects illegal writes.
- Returns read data plus a fault flag over a valid/ready response channel.

Parameters:
- ROM_TOP, 8'h80: first address above ROM.
- RW_TOP, 8'hE0: first address above RW data; the input-port region starts here.
- IN_TOP, 8'hF0: first address above the input ports; the output-port region starts here.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  sequencer can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  8  byte address.
- req_wdata  input  8  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU consumes response.
- resp_rdata  output  8  load data; 0x00 for stores.
- resp_fault  output  1  illegal access flag.
- mem_address  output  8  to memory address.
- mem_write  output  1  to memory write.
- mem_data_in  output  8  to memory data_in.
- mem_data_out  input  8  from memory data_out.
- stat_reads  output  16  completed loads (optional feature).
- stat_writes  output  16  committed stores (optional feature).
- stat_faults  output  16  faulted accesses (optional feature).

Behaviour:
- Reset: clk and a single-bit reset; reset is synchronous, active-low. Any edge with reset=0 forces:
  - state IDLE, req_ready=1, resp_valid=0, resp_fault=0;
  - resp_rdata=0x00, mem_address=0x00, mem_data_in=0x00, stat counters=0.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_addr/req_we/req_wdata into holding registers and go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = held address; mem_data_in = held wdata.
  - mem_write = held_we & legal & reset, combinational, so a reset-low edge suppresses the write.
  - Go to CAPTURE.
- CAPTURE (one cycle):
  - mem_address held.
  - On exit edge, resp_rdata captures mem_data_out for loads in ROM, RW or input-port regions.
  - Loads from the output-port region (>= IN_TOP) capture 0x00; these are not faults.
  - Stores capture 0x00.
  - Go to RESP.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_fault stay stable until an edge with resp_ready=1, then go to IDLE.
- Legality:
  - Store with addr < ROM_TOP, or RW_TOP <= addr < IN_TOP, is illegal: mem_write never asserts, resp_fault=1.
  - All loads are legal.
- Latency: acceptance edge t; resp_valid high after edge t+2; minimum 4 cycles per transaction.
- mem_address holds its last value in IDLE; mem_write=0 in every state except a legal ACCESS.
- req_ready=0 outside IDLE; req_valid in other states is ignored and not queued.
- resp_valid never deasserts without a resp_ready handshake, except on reset.
- Reset mid-transaction: the transaction is dropped, no response is issued, and no write occurs if reset is low at the ACCESS exit edge.

Optional Feature:
- Macro: ACCESS_STATS_EN.
- Defined: three 16-bit saturating counters (hold at 0xFFFF), each updated on the response handshake edge:
  - stat_reads increments on load completion;
  - stat_writes increments on legal store completion;
  - stat_faults increments on faulted completion.
- Undefined: counter logic is absent; stat_* ports exist and are tied to 0x0000.

Test Plan:
- Reset held low 2 cycles -> req_ready=1, resp_valid=0, mem_write=0, mem_address=0x00, stats 0x0000.
- Store 0x5A to 0x90, then load 0x90 -> mem_write high exactly one cycle with mem_address=0x90 and mem_data_in=0x5A; load resp_rdata=0x5A, resp_fault=0, resp_valid two cycles after acceptance.
- Store 0x33 to 0x10, then store 0x77 to 0xE5 -> mem_write never asserts, resp_fault=1 both times; a later load of 0x10 returns the ROM contents unchanged.
- Load 0xE3 with input port 3 = 0xC4 -> resp_rdata=0xC4; load 0xF2 -> resp_rdata=0x00, resp_fault=0.
- Load 0x85 with resp_ready=0 for 5 cycles and req_valid toggling -> resp_valid, resp_rdata and req_ready=0 all stable, new request not accepted until one edge after the handshake.
- Reset low on the ACCESS edge of a store of 0xAA to 0x90 -> mem_write=0 at that edge, 0x90 keeps 0x5A, FSM in IDLE, no response. With ACCESS_STATS_EN, after the second and third scenarios: stat_reads=1, stat_writes=1, stat_faults=2.
